letter_key_encoder: RTL and testbench
=====================================

Name: letter_key_encoder

Overview:
- Input-side counterpart of the seven-segment letter display driver: it turns the 13 letter push-buttons/switches into the same 4-bit letter code the display decoder consumes.
- Output is a one-cycle key_valid strobe plus error and held flags, for use by the scoring/game-control logic.
- Per-input synchronisation, shared debounce, single-key enforcement, optional auto-repeat.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive clk cycles the synchronised key vector must be unchanged before it is accepted (10 ms at 100 MHz); minimum 2.
- REPEAT_DELAY, 50000000: cycles a single key must be held before the first auto-repeat strobe (used only with the optional feature).
- REPEAT_RATE, 20000000: cycles between subsequent auto-repeat strobes (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- clr  input  1  reset, asynchronous, active-high.
- en  input  1  1 = strobes enabled (play mode); 0 = key tracking continues, key_valid/key_err suppressed.
- key_in  input  13  raw letter lines, asynchronous to clk. Bit i = code i: 0 A, 1 B, 2 C, 3 E, 4 F, 5 H, 6 I, 7 J, 8 L, 9 O, 10 P, 11 S, 12 U.
- key_code  output  4  last accepted letter code, 0..12.
- key_valid  output  1  one-cycle strobe: new accepted key.
- key_held  output  1  high while the accepted single key remains pressed.
- key_err  output  1  one-cycle strobe: illegal multi-key press detected.

Behaviour:
- Reset: clr=1 asynchronously forces the following to 0, and the FSM to IDLE.
  - sync stages, key_prev, key_stable, debounce counter, repeat counter
  - key_code, key_valid, key_held, key_err
- Synchroniser: 2-flop per bit, giving key_s.
- Debounce:
  - If key_s != key_prev: key_prev <= key_s and cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: key_stable <= key_prev and cnt holds.
  - Else cnt <= cnt+1.
  - Counter width is clog2(DEBOUNCE_CYCLES).
  - A glitch shorter than DEBOUNCE_CYCLES never reaches key_stable.
- FSM, evaluated on key_stable. States are IDLE, ONE, MULTI.
  - IDLE:
    - key_stable == 0: stay.
    - Exactly one bit set: go to ONE; key_code <= bit index; key_valid = en for one cycle.
    - Two or more bits set: go to MULTI; key_err = en for one cycle.
  - ONE:
    - key_stable equals the accepted one-hot: stay; key_held = 1.
    - key_stable == 0: go to IDLE; key_held = 0.
    - Any other nonzero value (extra key added, or slide to another key): go to MULTI; key_err = en. key_code is unchanged.
  - MULTI:
    - Stay until key_stable == 0, then go to IDLE. No strobes in MULTI.
  - Consequence: a full release is required between accepted keys.
- Latency:
  - key_valid rises exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the new key_in value.
  - This is 2 sync + DEBOUNCE_CYCLES debounce + 1 FSM register.
  - All outputs are registered.
- key_code holds its value until the next acceptance; it is not cleared on release.
- en low: the FSM still tracks key_stable.
  - A key pressed while en=0 and still held when en rises produces no key_valid; the player must release and re-press.
  - en changes never reset the FSM.
- key_valid and key_err are never high in the same cycle. Each is at most one cycle wide per event, except for auto-repeat.
- Key held through reset release: key_prev restarts at 0, so the key is debounced and accepted as a fresh press.
- Reset mid-debounce or mid-hold: no strobe is produced for the interrupted event.

Optional Feature:
- Macro: LETTER_KEY_REPEAT_EN.
- Defined:
  - In ONE with en=1, the repeat counter counts held cycles.
  - key_valid pulses again (same key_code) after REPEAT_DELAY cycles, then every REPEAT_RATE cycles while held.
  - The counter clears on leaving ONE and on any en=0 cycle.
- Not defined:
  - Exactly one key_valid per press.
  - No repeat counter is synthesised; REPEAT_DELAY and REPEAT_RATE are ignored.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8 for simulation):
- Reset: clr=1 for 3 cycles then 0 with key_in=0 -> all outputs 0, no strobes for 50 cycles.
- Clean press: en=1, key_in[5] (H) held 30 cycles -> key_valid high for exactly 1 cycle, 7 edges after the press; key_code=5; key_held=1 until 8 cycles after release; key_code stays 5 afterwards.
- Bounce: key_in[0] toggled every 2 cycles for 12 cycles then held -> exactly one key_valid with key_code=0, rising 7 edges after the last toggle.
- Multi-key: key_in[2] held 20 cycles (key_valid, code 2), then key_in[11] added -> one key_err pulse, key_code stays 2, key_held=0. Release both, then press key_in[12] -> key_valid with code 12.
- Enable gating: press key_in[9] with en=0, raise en while held, release, re-press -> no strobe until the re-press, then key_valid with code 9.
- Repeat (macro defined): hold key_in[3] for 60 cycles with en=1 -> key_valid at t0, t0+20, t0+28, t0+36, t0+44, t0+52, all with code 3. Macro undefined -> only the t0 pulse.

Source files
------------

// File: rtl/letter_key_encoder.sv
// Letter push-button encoder: per-bit 2-flop sync, shared debounce, single-key FSM.
// Optional auto-repeat of a held key is built when LETTER_KEY_REPEAT_EN is defined.
module letter_key_encoder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 20000000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic [12:0] key_in,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic        key_err
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, ONE, MULTI} state_t;

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 0 || REPEAT_RATE < 0) begin : g_paramCheck
    $error("letter_key_encoder: invalid parameter value");
  end

  logic [12:0]   syncA_q, syncB_q;
  logic [12:0]   keyPrev_q, keyStable_q;
  logic [CW-1:0] cnt_q;
  state_t        state_q, state_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
  logic          err_q, err_d;
  logic [3:0]    stableIdx;
  logic          stableOneHot;
  logic [12:0]   acceptedMask;

`ifdef LETTER_KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      syncA_q <= '0;
      syncB_q <= '0;
    end else begin
      syncA_q <= key_in;
      syncB_q <= syncA_q;
    end
  end

  // Any change restarts the count; the vector is accepted once it has sat still long enough.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      keyPrev_q   <= '0;
      keyStable_q <= '0;
      cnt_q       <= '0;
    end else if (syncB_q != keyPrev_q) begin
      keyPrev_q <= syncB_q;
      cnt_q     <= '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      keyStable_q <= keyPrev_q;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_comb begin
    stableIdx = '0;
    for (int i = 0; i < 13; i++) begin
      if (keyStable_q[i]) stableIdx = 4'(i);
    end
  end

  assign stableOneHot = (keyStable_q != '0) && ((keyStable_q & (keyStable_q - 13'd1)) == '0);
  assign acceptedMask = 13'd1 << code_q;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = 1'b0;
    err_d   = 1'b0;
`ifdef LETTER_KEY_REPEAT_EN
    rep_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (stableOneHot) begin
          state_d = ONE;
          code_d  = stableIdx;
          valid_d = en;
          held_d  = 1'b1;
        end else if (keyStable_q != '0) begin
          state_d = MULTI;
          err_d   = en;
        end
      end
      ONE: begin
        if (keyStable_q == '0) begin
          state_d = IDLE;
        end else if (keyStable_q == acceptedMask) begin
          held_d = 1'b1;
`ifdef LETTER_KEY_REPEAT_EN
          // First repeat after REPEAT_DELAY, then the counter is rewound so the next hit is REPEAT_RATE later.
          if (en) begin
            rep_d = rep_q + RW'(1);
            if (rep_d == RW'(REPEAT_DELAY)) begin
              valid_d = 1'b1;
              rep_d   = RW'(REPEAT_DELAY - REPEAT_RATE);
            end
          end
`endif
        end else begin
          state_d = MULTI;
          err_d   = en;
        end
      end
      MULTI: begin
        if (keyStable_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      err_q   <= err_d;
    end
  end

`ifdef LETTER_KEY_REPEAT_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) rep_q <= '0;
    else     rep_q <= rep_d;
  end
`endif

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign key_err   = err_q;

endmodule

// File: tb/tb_letter_key_encoder.sv
// Testbench for letter_key_encoder: directed scenarios plus random key traffic,
// every cycle compared against a sample-window reference model.
module tb_letter_key_encoder;

  localparam int DEB    = 4;
  localparam int RDELAY = 20;
  localparam int RRATE  = 8;
  localparam int HLEN   = DEB + 3;

  logic        clk = 1'b0;
  logic        clr;
  logic        en;
  logic [12:0] key_in;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        key_err;

  always #5 clk = ~clk;

  letter_key_encoder #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RDELAY),
    .REPEAT_RATE(RRATE)
  ) dut (
    .clk(clk),
    .clr(clr),
    .en(en),
    .key_in(key_in),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held),
    .key_err(key_err)
  );

  int checks = 0;
  int failures = 0;
  int edgeNum = 0;
  int validCount = 0;
  int errCount = 0;
  int lastValidEdge = -1;
  int pressEdge = 0;

  // Reference state: raw key samples per edge, the accepted vector, and press bookkeeping.
  logic [12:0] hist [HLEN];
  logic [12:0] mStable;
  logic [12:0] single;
  bit          locked;
  int          repCount;
  logic [3:0]  expCode;
  logic        expValid, expHeld, expErr;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, observed, expected, edgeNum);
    end
  endtask

  task automatic modelReset();
    for (int j = 0; j < HLEN; j++) hist[j] = '0;
    mStable  = '0;
    single   = '0;
    locked   = 1'b0;
    repCount = 0;
    expCode  = '0;
    expValid = 1'b0;
    expHeld  = 1'b0;
    expErr   = 1'b0;
  endtask

  // A vector is accepted once DEB+1 consecutive raw samples agree, two edges of sync delay earlier.
  task automatic modelStep();
    logic [12:0] s;
    bit allSame;
    for (int j = HLEN - 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = key_in;
    s = mStable;
    expValid = 1'b0;
    expErr   = 1'b0;
    if (s == '0) begin
      locked   = 1'b0;
      single   = '0;
      repCount = 0;
    end else if (!locked) begin
      locked   = 1'b1;
      repCount = 0;
      if ($countones(s) == 1) begin
        single = s;
        for (int i = 0; i < 13; i++) if (s[i]) expCode = 4'(i);
        expValid = en;
      end else begin
        expErr = en;
      end
    end else if (single != '0 && s != single) begin
      expErr = en;
      single = '0;
    end else if (single != '0) begin
`ifdef LETTER_KEY_REPEAT_EN
      if (!en) repCount = 0;
      else begin
        repCount++;
        if (repCount == RDELAY || (repCount > RDELAY && (repCount - RDELAY) % RRATE == 0))
          expValid = 1'b1;
      end
`endif
    end
    expHeld = (single != '0);
    allSame = 1'b1;
    for (int j = 3; j < HLEN; j++) if (hist[j] != hist[2]) allSame = 1'b0;
    if (allSame) mStable = hist[2];
  endtask

  task automatic compareAll();
    checkOutput("key_code", key_code, expCode);
    checkOutput("key_valid", key_valid, expValid);
    checkOutput("key_held", key_held, expHeld);
    checkOutput("key_err", key_err, expErr);
    checkOutput("valid_err_exclusive", key_valid & key_err, 0);
    if (key_valid) begin
      validCount++;
      lastValidEdge = edgeNum;
    end
    if (key_err) errCount++;
  endtask

  task automatic applyStimulus(input logic [12:0] k, input logic e, input int cycles);
    key_in    = k;
    en        = e;
    pressEdge = edgeNum + 1;
    repeat (cycles) begin
      @(posedge clk);
      edgeNum++;
      modelStep();
      @(negedge clk);
      compareAll();
    end
  endtask

  task automatic resetDut();
    clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    modelReset();
    clr = 1'b0;
    checkOutput("reset_key_code", key_code, 0);
    checkOutput("reset_key_valid", key_valid, 0);
    checkOutput("reset_key_held", key_held, 0);
    checkOutput("reset_key_err", key_err, 0);
  endtask

  initial begin
    int r, d, a, b;
    logic [12:0] k;
    key_in = '0;
    en     = 1'b0;
    clr    = 1'b1;
    modelReset();

    $display("[TB] reset");
    resetDut();
    validCount = 0;
    applyStimulus('0, 1'b1, 50);
    checkOutput("reset_no_strobe", validCount + errCount, 0);

    $display("[TB] clean press");
    validCount = 0;
    applyStimulus(13'd1 << 5, 1'b1, 30);
    checkOutput("clean_valid_count", validCount, 1);
    checkOutput("clean_latency", lastValidEdge - pressEdge, 7);
    applyStimulus('0, 1'b1, 20);
    checkOutput("clean_code_kept", key_code, 5);
    checkOutput("clean_held_released", key_held, 0);

    $display("[TB] bounce");
    validCount = 0;
    for (int t = 0; t < 3; t++) begin
      applyStimulus(13'd1, 1'b1, 2);
      applyStimulus('0, 1'b1, 2);
    end
    applyStimulus(13'd1, 1'b1, 20);
    checkOutput("bounce_valid_count", validCount, 1);
    checkOutput("bounce_latency", lastValidEdge - pressEdge, 7);
    checkOutput("bounce_code", key_code, 0);
    applyStimulus('0, 1'b1, 15);

    $display("[TB] multi-key");
    validCount = 0;
    errCount   = 0;
    applyStimulus(13'd1 << 2, 1'b1, 20);
    applyStimulus((13'd1 << 2) | (13'd1 << 11), 1'b1, 15);
    checkOutput("multi_err_count", errCount, 1);
    checkOutput("multi_code_kept", key_code, 2);
    checkOutput("multi_held_low", key_held, 0);
    applyStimulus('0, 1'b1, 15);
    applyStimulus(13'd1 << 12, 1'b1, 15);
    checkOutput("multi_next_code", key_code, 12);
    checkOutput("multi_valid_count", validCount, 2);
    applyStimulus('0, 1'b1, 15);

    $display("[TB] enable gating");
    validCount = 0;
    applyStimulus(13'd1 << 9, 1'b0, 12);
    applyStimulus(13'd1 << 9, 1'b1, 10);
    applyStimulus('0, 1'b1, 12);
    checkOutput("gate_no_strobe", validCount, 0);
    applyStimulus(13'd1 << 9, 1'b1, 15);
    checkOutput("gate_repress_count", validCount, 1);
    checkOutput("gate_repress_code", key_code, 9);
    applyStimulus('0, 1'b1, 15);

    $display("[TB] long hold");
    validCount = 0;
    applyStimulus(13'd1 << 3, 1'b1, 60);
`ifdef LETTER_KEY_REPEAT_EN
    checkOutput("hold_valid_count", validCount, 6);
`else
    checkOutput("hold_valid_count", validCount, 1);
`endif
    applyStimulus('0, 1'b1, 15);

    $display("[TB] reset during debounce and hold");
    validCount = 0;
    applyStimulus(13'd1 << 7, 1'b1, 3);
    resetDut();
    key_in = '0;
    applyStimulus('0, 1'b1, 20);
    checkOutput("reset_mid_debounce", validCount, 0);
    applyStimulus(13'd1 << 6, 1'b1, 3);
    resetDut();
    applyStimulus(13'd1 << 6, 1'b1, 15);
    checkOutput("held_through_reset_count", validCount, 1);
    checkOutput("held_through_reset_code", key_code, 6);
    applyStimulus('0, 1'b1, 15);

    $display("[TB] random traffic");
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      a = $urandom_range(0, 12);
      b = $urandom_range(0, 12);
      if (r < 4)      k = '0;
      else if (r < 8) k = 13'd1 << a;
      else            k = (13'd1 << a) | (13'd1 << b);
      d = $urandom_range(1, 12);
      applyStimulus(k, ($urandom_range(0, 5) != 0), d);
    end
    applyStimulus('0, 1'b1, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
